// File: rtl/rgb_to_yuv422_encoder.sv
// RGB frame to planar YUV 4:2:2 encoder: reads interleaved RGB words from SRAM and writes Y, U, V segments.
// One 4-pixel group per 10-cycle loop through a shared three-multiplier datapath.
module rgb_to_yuv422_encoder #(
  parameter int unsigned Y_BASE   = 0,
  parameter int unsigned U_BASE   = 38400,
  parameter int unsigned V_BASE   = 57600,
  parameter int unsigned RGB_BASE = 146944,
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 240
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        start_bit,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] address,
  output logic [15:0] write_data,
  output logic        write_en_n,
  output logic        encoder_finish
);
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned RGB_WORDS = 3 * WIDTH * HEIGHT / 2;
  localparam logic [ADDR_W-1:0] RGB_END = ADDR_W'(RGB_BASE + RGB_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LEAD_IN, S_COMMON, S_LEAD_OUT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         phase_q, phase_d;
  logic [ADDR_W-1:0]  rgb_addr_q, rgb_addr_d, y_addr_q, y_addr_d;
  logic [ADDR_W-1:0]  u_addr_q, u_addr_d, v_addr_q, v_addr_d;
  logic [15:0]        nxt_q [6];
  logic [15:0]        nxt_d [6];
  logic [15:0]        cur_q [6];
  logic [15:0]        cur_d [6];
  logic [7:0]         y_q [4];
  logic [7:0]         y_d [4];
  logic [7:0]         u_q [2];
  logic [7:0]         u_d [2];
  logic [7:0]         v_q [2];
  logic [7:0]         v_d [2];
  logic [ADDR_W-1:0]  address_d;
  logic [15:0]        write_data_d;
  logic               write_en_n_d, encoder_finish_d;
  logic               fetch, calc;

  logic [7:0]         pr [4];
  logic [7:0]         pg [4];
  logic [7:0]         pb [4];
  logic [7:0]         ra [2];
  logic [7:0]         ga [2];
  logic [7:0]         ba [2];
  logic [7:0]         op_r, op_g, op_b;
  logic signed [31:0] k_r, k_g, k_b, k_off;
  logic signed [31:0] prod_r, prod_g, prod_b, acc, acc_sh;
  logic [7:0]         clip_val;

  assign fetch = (state_q == S_LEAD_IN) || (state_q == S_COMMON);
  assign calc  = (state_q == S_COMMON) || (state_q == S_LEAD_OUT);

  // Unpack the current group's six words into pixels and pair averages
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pr[2*p]   = cur_q[3*p][15:8];
      pg[2*p]   = cur_q[3*p][7:0];
      pb[2*p]   = cur_q[3*p+1][15:8];
      pr[2*p+1] = cur_q[3*p+1][7:0];
      pg[2*p+1] = cur_q[3*p+2][15:8];
      pb[2*p+1] = cur_q[3*p+2][7:0];
      ra[p] = 8'((9'(pr[2*p]) + 9'(pr[2*p+1]) + 9'd1) >> 1);
      ga[p] = 8'((9'(pg[2*p]) + 9'(pg[2*p+1]) + 9'd1) >> 1);
      ba[p] = 8'((9'(pb[2*p]) + 9'(pb[2*p+1]) + 9'd1) >> 1);
    end
  end

  // Phase schedule: 0-3 Y of pixels 0-3, 4-5 U of pairs 0-1, 6-7 V of pairs 0-1
  always_comb begin
    op_r  = pr[phase_q[1:0]];
    op_g  = pg[phase_q[1:0]];
    op_b  = pb[phase_q[1:0]];
    k_r   = 32'sd16843;
    k_g   = 32'sd33030;
    k_b   = 32'sd6423;
    k_off = 32'sd1081344;
    if (phase_q >= 4'd4) begin
      op_r  = ra[phase_q[0]];
      op_g  = ga[phase_q[0]];
      op_b  = ba[phase_q[0]];
      k_off = 32'sd8421376;
      if (phase_q < 4'd6) begin
        k_r = -32'sd9699;
        k_g = -32'sd19071;
        k_b = 32'sd28770;
      end else begin
        k_r = 32'sd28770;
        k_g = -32'sd24117;
        k_b = -32'sd4653;
      end
    end
  end

  assign prod_r   = k_r * $signed({24'd0, op_r});
  assign prod_g   = k_g * $signed({24'd0, op_g});
  assign prod_b   = k_b * $signed({24'd0, op_b});
  assign acc      = prod_r + prod_g + prod_b + k_off;
  assign acc_sh   = acc >>> 16;
  assign clip_val = (acc_sh < 0) ? 8'd0 : (acc_sh > 32'sd255) ? 8'd255 : acc_sh[7:0];

  // Next-state, address sequencing and SRAM access per phase
  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    rgb_addr_d       = rgb_addr_q;
    y_addr_d         = y_addr_q;
    u_addr_d         = u_addr_q;
    v_addr_d         = v_addr_q;
    nxt_d            = nxt_q;
    cur_d            = cur_q;
    y_d              = y_q;
    u_d              = u_q;
    v_d              = v_q;
    address_d        = address;
    write_data_d     = write_data;
    write_en_n_d     = 1'b1;
    encoder_finish_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d    = '0;
        rgb_addr_d = ADDR_W'(RGB_BASE);
        y_addr_d   = ADDR_W'(Y_BASE);
        u_addr_d   = ADDR_W'(U_BASE);
        v_addr_d   = ADDR_W'(V_BASE);
        if (start_bit) state_d = S_LEAD_IN;
      end
      S_LEAD_IN, S_COMMON, S_LEAD_OUT: begin
        phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
        if (fetch && phase_q <= 4'd5) begin
          address_d  = rgb_addr_q;
          rgb_addr_d = rgb_addr_q + ADDR_W'(1);
        end
        // Read data lands three cycles after its address is registered
        if (fetch && phase_q >= 4'd3 && phase_q <= 4'd8)
          nxt_d[3'(phase_q - 4'd3)] = SRAM_read_data;
        if (calc) begin
          case (phase_q)
            4'd0, 4'd1, 4'd2, 4'd3: y_d[phase_q[1:0]] = clip_val;
            4'd4, 4'd5:             u_d[phase_q[0]]   = clip_val;
            4'd6, 4'd7:             v_d[phase_q[0]]   = clip_val;
            default: ;
          endcase
          case (phase_q)
            4'd6: begin
              write_en_n_d = 1'b0;
              address_d    = y_addr_q;
              write_data_d = {y_q[0], y_q[1]};
              y_addr_d     = y_addr_q + ADDR_W'(1);
            end
            4'd7: begin
              write_en_n_d = 1'b0;
              address_d    = y_addr_q;
              write_data_d = {y_q[2], y_q[3]};
              y_addr_d     = y_addr_q + ADDR_W'(1);
            end
            4'd8: begin
              write_en_n_d = 1'b0;
              address_d    = u_addr_q;
              write_data_d = {u_q[0], u_q[1]};
              u_addr_d     = u_addr_q + ADDR_W'(1);
            end
            4'd9: begin
              write_en_n_d = 1'b0;
              address_d    = v_addr_q;
              write_data_d = {v_q[0], v_q[1]};
              v_addr_d     = v_addr_q + ADDR_W'(1);
            end
            default: ;
          endcase
        end
        if (phase_q == 4'd9) begin
          if (fetch) begin
            cur_d   = nxt_q;
            state_d = (rgb_addr_q == RGB_END) ? S_LEAD_OUT : S_COMMON;
          end else begin
            state_d          = S_DONE;
            encoder_finish_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      phase_q        <= '0;
      rgb_addr_q     <= '0;
      y_addr_q       <= '0;
      u_addr_q       <= '0;
      v_addr_q       <= '0;
      for (int i = 0; i < 6; i++) begin
        nxt_q[i] <= '0;
        cur_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        u_q[i] <= '0;
        v_q[i] <= '0;
      end
      address        <= '0;
      write_data     <= '0;
      write_en_n     <= 1'b1;
      encoder_finish <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      rgb_addr_q     <= rgb_addr_d;
      y_addr_q       <= y_addr_d;
      u_addr_q       <= u_addr_d;
      v_addr_q       <= v_addr_d;
      nxt_q          <= nxt_d;
      cur_q          <= cur_d;
      y_q            <= y_d;
      u_q            <= u_d;
      v_q            <= v_d;
      address        <= address_d;
      write_data     <= write_data_d;
      write_en_n     <= write_en_n_d;
      encoder_finish <= encoder_finish_d;
    end
  end
endmodule

// File: tb/tb_rgb_to_yuv422_encoder.sv
// Bench for rgb_to_yuv422_encoder on a reduced 8x4 frame with an SRAM model and a pixel-level reference.
`timescale 1ns/1ps
module tb_rgb_to_yuv422_encoder;
  localparam int W = 8, H = 4;
  localparam int YB = 0, UB = 16, VB = 24, RB = 64;
  localparam int NPIX = W * H, NPAIR = NPIX / 2, NG = NPIX / 4, NRGB = 3 * NPAIR;
  localparam int CYC_BOUND = 10 * NG + 100;
  localparam int MEM_N = 256;
  localparam int K_ZERO = 0, K_ONES = 1, K_RED = 2, K_RB = 3, K_RAND = 4;

  logic        clk = 1'b0;
  logic        rst, start_bit;
  logic [15:0] rd_data;
  logic [17:0] address;
  logic [15:0] write_data;
  logic        write_en_n, encoder_finish;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rgb_to_yuv422_encoder #(
    .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .CLOCK_50_I(clk),
    .Reset(rst),
    .start_bit(start_bit),
    .SRAM_read_data(rd_data),
    .address(address),
    .write_data(write_data),
    .write_en_n(write_en_n),
    .encoder_finish(encoder_finish)
  );

  logic [15:0] mem [MEM_N];
  logic [15:0] img [MEM_N];
  logic [15:0] rd_p0, rd_p1;
  logic        load_now, mon_clr, prev_wen_n;
  int          wr_cnt, oob_cnt, fin_cnt, period_bad, cyc, last_burst, burst_len;
  int          exp_y [NPIX];
  int          exp_u [NPAIR];
  int          exp_v [NPAIR];

  assign rd_data = rd_p1;

  // SRAM with two-register read path, plus write/finish monitor
  always @(posedge clk) begin
    rd_p0      <= (int'(address) < MEM_N) ? mem[address[7:0]] : 16'h0000;
    rd_p1      <= rd_p0;
    cyc        <= cyc + 1;
    prev_wen_n <= write_en_n;
    if (load_now) begin
      for (int i = 0; i < MEM_N; i++) mem[i] <= img[i];
    end else if (!write_en_n && int'(address) < MEM_N) begin
      mem[address[7:0]] <= write_data;
    end
    if (mon_clr) begin
      wr_cnt <= 0; oob_cnt <= 0; fin_cnt <= 0; period_bad <= 0;
      last_burst <= -1; burst_len <= 0;
    end else begin
      if (encoder_finish) fin_cnt <= fin_cnt + 1;
      if (!write_en_n) begin
        wr_cnt <= wr_cnt + 1;
        if (int'(address) > VB + NG - 1) oob_cnt <= oob_cnt + 1;
        if (prev_wen_n) begin
          if (last_burst >= 0 && cyc - last_burst != 10) period_bad <= period_bad + 1;
          last_burst <= cyc;
          burst_len  <= 1;
        end else begin
          burst_len <= burst_len + 1;
        end
      end else if (!prev_wen_n && burst_len != 4) begin
        period_bad <= period_bad + 1;
      end
    end
  end

  function automatic int clip_shift(input int v);
    int s;
    s = v >>> 16;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic build_model();
    int r0, g0, b0, r1, g1, b1, ra, ga, ba;
    logic [15:0] w0, w1, w2;
    for (int p = 0; p < NPAIR; p++) begin
      w0 = img[RB + 3*p]; w1 = img[RB + 3*p + 1]; w2 = img[RB + 3*p + 2];
      r0 = int'(w0[15:8]); g0 = int'(w0[7:0]);  b0 = int'(w1[15:8]);
      r1 = int'(w1[7:0]);  g1 = int'(w2[15:8]); b1 = int'(w2[7:0]);
      exp_y[2*p]   = clip_shift(16843*r0 + 33030*g0 + 6423*b0 + 1081344);
      exp_y[2*p+1] = clip_shift(16843*r1 + 33030*g1 + 6423*b1 + 1081344);
      ra = (r0 + r1 + 1) >> 1; ga = (g0 + g1 + 1) >> 1; ba = (b0 + b1 + 1) >> 1;
      exp_u[p] = clip_shift(-9699*ra - 19071*ga + 28770*ba + 8421376);
      exp_v[p] = clip_shift(28770*ra - 24117*ga - 4653*ba + 8421376);
    end
  endtask

  task automatic load_image(input int kind);
    logic [15:0] w [3];
    for (int i = 0; i < MEM_N; i++) img[i] = 16'hDEAD;
    for (int p = 0; p < NPAIR; p++) begin
      case (kind)
        K_ZERO:  begin w[0] = 16'h0000; w[1] = 16'h0000; w[2] = 16'h0000; end
        K_ONES:  begin w[0] = 16'hFFFF; w[1] = 16'hFFFF; w[2] = 16'hFFFF; end
        K_RED:   begin w[0] = 16'hFF00; w[1] = 16'h00FF; w[2] = 16'h0000; end
        K_RB:    begin w[0] = 16'hFF00; w[1] = 16'h0000; w[2] = 16'h0000; end
        default: begin w[0] = 16'($urandom); w[1] = 16'($urandom); w[2] = 16'($urandom); end
      endcase
      for (int j = 0; j < 3; j++) img[RB + 3*p + j] = w[j];
    end
    @(posedge clk); #1 load_now = 1'b1;
    @(posedge clk); #1 load_now = 1'b0;
    build_model();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (address !== 18'd0) begin errors++; $display("FAIL reset_address got %h want 0", address); end
    checks++; if (write_data !== 16'd0) begin errors++; $display("FAIL reset_write_data got %h want 0", write_data); end
    checks++; if (write_en_n !== 1'b1) begin errors++; $display("FAIL reset_write_en_n got %b want 1", write_en_n); end
    checks++; if (encoder_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", encoder_finish); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Encode one frame and compare every output word; sy/su/sv >= 0 add fixed expected words
  task automatic test_frame(input int kind, input string name, input bit reload,
                            input int sy, input int su, input int sv, input int extra_start);
    int cycles;
    logic [15:0] got, want;
    if (reload) load_image(kind);
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
    start_bit = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    while (!encoder_finish && cycles < CYC_BOUND) begin
      start_bit = (cycles == extra_start);
      @(posedge clk); #1;
      cycles++;
    end
    start_bit = 1'b0;
    checks++;
    if (encoder_finish !== 1'b1) begin
      errors++; $display("FAIL %s finish_latency got %0d cycles without finish, required <= %0d", name, cycles, CYC_BOUND);
    end
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < NPIX / 2; k++) begin
      got  = mem[YB + k];
      want = 16'((exp_y[2*k] << 8) | exp_y[2*k+1]);
      checks++; if (got !== want) begin errors++; $display("FAIL %s Y[%0d] got %h want %h", name, k, got, want); end
      if (sy >= 0) begin
        checks++; if (got !== 16'(sy)) begin errors++; $display("FAIL %s Yconst[%0d] got %h want %h", name, k, got, 16'(sy)); end
      end
    end
    for (int m = 0; m < NG; m++) begin
      got  = mem[UB + m];
      want = 16'((exp_u[2*m] << 8) | exp_u[2*m+1]);
      checks++; if (got !== want) begin errors++; $display("FAIL %s U[%0d] got %h want %h", name, m, got, want); end
      if (su >= 0) begin
        checks++; if (got !== 16'(su)) begin errors++; $display("FAIL %s Uconst[%0d] got %h want %h", name, m, got, 16'(su)); end
      end
      got  = mem[VB + m];
      want = 16'((exp_v[2*m] << 8) | exp_v[2*m+1]);
      checks++; if (got !== want) begin errors++; $display("FAIL %s V[%0d] got %h want %h", name, m, got, want); end
      if (sv >= 0) begin
        checks++; if (got !== 16'(sv)) begin errors++; $display("FAIL %s Vconst[%0d] got %h want %h", name, m, got, 16'(sv)); end
      end
    end
    for (int i = 0; i < NRGB; i++) begin
      checks++;
      if (mem[RB + i] !== img[RB + i]) begin
        errors++; $display("FAIL %s rgb_kept[%0d] got %h want %h", name, i, mem[RB + i], img[RB + i]);
      end
    end
    checks++; if (wr_cnt != 4 * NG) begin errors++; $display("FAIL %s write_count got %0d want %0d", name, wr_cnt, 4 * NG); end
    checks++; if (oob_cnt != 0) begin errors++; $display("FAIL %s out_of_bounds_writes got %0d want 0", name, oob_cnt); end
    checks++; if (period_bad != 0) begin errors++; $display("FAIL %s group_period_violations got %0d want 0", name, period_bad); end
    checks++; if (fin_cnt != 1) begin errors++; $display("FAIL %s finish_pulses got %0d want 1", name, fin_cnt); end
  endtask

  task automatic test_midframe_reset();
    int n;
    load_image(K_RAND);
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
    start_bit = 1'b1;
    @(posedge clk); #1 start_bit = 1'b0;
    n = 0;
    while (wr_cnt < 10 && n < CYC_BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (wr_cnt < 10) begin errors++; $display("FAIL midreset_progress got %0d writes want >= 10", wr_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (write_en_n !== 1'b1) begin errors++; $display("FAIL midreset_wen got %b want 1", write_en_n); end
    checks++; if (address !== 18'd0) begin errors++; $display("FAIL midreset_address got %h want 0", address); end
    mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL midreset_quiet_writes got %0d want 0", wr_cnt); end
    checks++; if (fin_cnt != 0) begin errors++; $display("FAIL midreset_quiet_finish got %0d want 0", fin_cnt); end
  endtask

  initial begin
    rst = 1'b0; start_bit = 1'b0; load_now = 1'b0; mon_clr = 1'b0;
    test_reset();
    test_frame(K_ZERO, "all_zero", 1'b1, 16'h1010, 16'h8080, 16'h8080, -1);
    test_frame(K_ONES, "all_ones", 1'b1, 16'hEBEB, 16'h8080, 16'h8080, -1);
    test_frame(K_RED,  "pure_red", 1'b1, 16'h5252, 16'h5A5A, 16'hF0F0, -1);
    test_frame(K_RB,   "red_black", 1'b1, 16'h5210, 16'h6D6D, 16'hB8B8, -1);
    test_frame(K_RAND, "random_a", 1'b1, -1, -1, -1, -1);
    test_frame(K_RAND, "random_stray_start", 1'b1, -1, -1, -1, 25);
    test_midframe_reset();
    test_frame(K_RAND, "restart_after_reset", 1'b0, -1, -1, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rgb_to_yuv422_encoder.md
RGB_TO_YUV422_ENCODER -- requirements
Module: rgb_to_yuv422_encoder

Interface
REQ-001 Parameters: Y_BASE default 0 (Y segment word address); U_BASE default 38400; V_BASE default 57600; RGB_BASE default 146944; WIDTH default 320 (pixels/row); HEIGHT default 240 (rows).
REQ-002 CLOCK_50_I  input  1  sole clock, all state updates on rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-high.
REQ-004 start_bit  input  1  level; starts one frame encode when sampled high in S_IDLE.
REQ-005 SRAM_read_data  input  16  SRAM read word, valid 3 cycles after the cycle that registers its address.
REQ-006 address  output  18  registered SRAM word address.
REQ-007 write_data  output  16  registered SRAM write word.
REQ-008 write_en_n  output  1  registered, active-low SRAM write enable.
REQ-009 encoder_finish  output  1  one-cycle completion pulse.

Function
REQ-010 The block SHALL read the interleaved RGB frame at RGB_BASE, with 3 words per pixel pair: {R0,G0}, {B0,R1}, {G1,B1}.
REQ-011 For every pixel, Y SHALL equal clip((16843*R + 33030*G + 6423*B + 1081344) >>> 16).
REQ-012 For each pixel pair, the block SHALL form Ra=(R0+R1+1)>>1, and likewise Ga and Ba.
REQ-013 U SHALL equal clip((-9699*Ra - 19071*Ga + 28770*Ba + 8421376) >>> 16), computed once per pair.
REQ-014 V SHALL equal clip((28770*Ra - 24117*Ga - 4653*Ba + 8421376) >>> 16), computed once per pair.
REQ-015 All products and sums SHALL be 32-bit signed; clip saturates to 0..255.
REQ-016 At most three 32x32 multipliers SHALL be instantiated.
REQ-017 Output layout: Y word k = {Y(2k), Y(2k+1)} at Y_BASE+k; U word m = {U(pair 2m), U(pair 2m+1)} at U_BASE+m; V word m likewise at V_BASE+m.
REQ-018 States SHALL be S_IDLE, S_LEAD_IN, S_COMMON, S_LEAD_OUT and S_DONE.
REQ-019 S_IDLE SHALL go to S_LEAD_IN when start_bit=1; otherwise it holds.
REQ-020 S_LEAD_IN SHALL prefetch the first group's 6 RGB words and then enter S_COMMON.
REQ-021 S_COMMON SHALL process one 4-pixel group per 10-cycle loop (phase counter 0-9): 6 reads of the next group and 4 writes of the previous group (Y, Y, U, V).
REQ-022 In S_COMMON the SRAM SHALL be accessed every cycle.
REQ-023 After the last prefetch (group WIDTH*HEIGHT/4 - 1 = 19199), the block SHALL go to S_LEAD_OUT, issue the remaining writes, then enter S_DONE.
REQ-024 S_DONE SHALL assert encoder_finish for exactly one cycle and return to S_IDLE.
REQ-025 Frame completion SHALL take at most 192,100 cycles from start_bit sampling to encoder_finish.
REQ-026 While write_en_n=0, address SHALL lie in [Y_BASE, V_BASE+19199]; RGB_BASE..RGB_BASE+115199 is never written.
REQ-027 During reads write_en_n SHALL be 1; write_data SHALL be stable in any write cycle.
REQ-028 start_bit SHALL be ignored outside S_IDLE.
REQ-029 Row boundaries need no special handling: pairs never straddle rows because WIDTH is even.
REQ-030 Address counters SHALL not wrap within a frame and SHALL reload to their base values in S_IDLE.

Reset
REQ-031 On Reset=1, outputs SHALL immediately become: address=0, write_data=0, write_en_n=1, encoder_finish=0.
REQ-032 On Reset=1, the state SHALL become S_IDLE and all counters, the phase and all pixel/accumulator registers SHALL become 0.
REQ-033 Reset asserted mid-frame SHALL abort with no further writes; after release the block waits for start_bit and re-encodes from base addresses.

Verification
REQ-034 All RGB words 0x0000 -> all Y words 0x1010 and all U/V words 0x8080; exactly 76,800 writes; one encoder_finish pulse.
REQ-035 All RGB words 0xFFFF -> Y words 0xEBEB; U/V words 0x8080.
REQ-036 Pure red (R=255,G=0,B=0) frame -> Y words 0x5252; U words 0x5A5A; V words 0xF0F0.
REQ-037 Pair red then black (words 0xFF00, 0x0000, 0x0000) -> Y word 0x5210; that pair's U byte 0x6D (109), V byte 0xB8 (184).
REQ-038 Reset pulsed during group 100, then start_bit -> write_en_n=1 within the reset cycle; no writes until restart; final memory matches a reset-free run.
REQ-039 The address/write monitor SHALL show, over the whole run, no writes outside REQ-026 bounds, a 10-cycle group period in S_COMMON, and completion within 192,100 cycles.
